// File: rtl/mips32_mem_responder_if.sv
// Request/response bundle between the MIPS32 pipeline (master) and its
// memory responder (slave).
//   if_*  : read-only instruction-fetch channel
//   dm_*  : read/write data-memory channel
// req/addr/wdata/we are held stable by the master until the matching ack
// pulse; rdata is valid in the ack cycle and holds afterwards.
interface mips32_mem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata
  );

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
    output if_ack, if_rdata, dm_ack, dm_rdata
  );
endinterface

// File: rtl/mips32_mem_responder.sv
// Word-addressed memory responder serving the IF (read) and DM (read/write)
// channels of the MIPS32 pipeline with WAIT wait states per access.
// Ports:
//   clk1 : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of mips32_mem_responder_if (both channels)
//   busy : high whenever a transaction is in flight (state != IDLE)
// One transaction at a time: IDLE samples and latches a grant, WAIT counts
// down and performs the access, RESP pulses the granted channel's ack.
module mips32_mem_responder #(
  parameter int          ADDR_W = 10,
  parameter int          DATA_W = 32,
  parameter int unsigned WAIT   = 1
) (
  input  logic                     clk1,
  input  logic                     rst,
  mips32_mem_responder_if.slave    bus,
  output logic                     busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  logic [2:0]        cnt;
  logic              last_dm;   // last grant went to DM
  logic              g_dm;      // current grant is DM
  logic              g_we;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;

  logic any_req;
  logic pick_dm;
  logic access;

  assign any_req = bus.if_req | bus.dm_req;
  // DM wins contention unless it won the previous grant.
  assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm);
  assign access  = (state == ST_WAIT) && (cnt == 3'd0);

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (any_req) state_nx = ST_WAIT;
      ST_WAIT: if (cnt == 3'd0) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= 3'd0;
      last_dm    <= 1'b0;
      g_dm       <= 1'b0;
      g_we       <= 1'b0;
      g_addr     <= '0;
      g_wdata    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            g_dm    <= pick_dm;
            last_dm <= pick_dm;
            g_we    <= pick_dm & bus.dm_we;
            g_addr  <= pick_dm ? bus.dm_addr : bus.if_addr;
            g_wdata <= bus.dm_wdata;
            cnt     <= 3'(WAIT);
          end
        end
        ST_WAIT: begin
          if (cnt != 3'd0)   cnt        <= cnt - 3'd1;
          else if (g_dm)     dm_rdata_q <= mem[g_addr];
          else               if_rdata_q <= mem[g_addr];
        end
        default: ;
      endcase
    end
  end

  // Store half of read-before-write; reset on the access edge drops it.
  always_ff @(posedge clk1) begin
    if (!rst && access && g_dm && g_we) mem[g_addr] <= g_wdata;
  end

  assign bus.if_ack   = (state == ST_RESP) && !g_dm;
  assign bus.dm_ack   = (state == ST_RESP) &&  g_dm;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_mips32_mem_responder.sv
module tb_mips32_mem_responder;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int W2 = 2;
  localparam int W3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic r2 = 1'b1, r3 = 1'b1, r0 = 1'b1;
  logic busy2, busy3, busy0;

  mips32_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();
  mips32_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();
  mips32_mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) b0 ();

  mips32_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT(W2)) u2 (.clk1(clk), .rst(r2), .bus(b2), .busy(busy2));
  mips32_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT(W3)) u3 (.clk1(clk), .rst(r3), .bus(b3), .busy(busy3));
  mips32_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .WAIT(0))  u0 (.clk1(clk), .rst(r0), .bus(b0), .busy(busy0));

  typedef struct { bit dm; logic [DW-1:0] d; } exp_t;
  exp_t sb[$];

  logic [DW-1:0] mdl [0:(2**AW)-1];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard side for the WAIT=2 instance: every ack pops one expectation.
  always @(negedge clk) begin
    if (!r2 && (b2.if_ack || b2.dm_ack)) begin
      chk("ack_exclusive", {31'd0, b2.if_ack & b2.dm_ack}, 32'd0);
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_channel", {31'd0, b2.dm_ack}, {31'd0, e.dm});
        chk("ack_rdata", e.dm ? b2.dm_rdata : b2.if_rdata, e.d);
      end
    end
  end

  task automatic preload2(input int a, input logic [DW-1:0] v);
    u2.mem[a] = v;
    mdl[a] = v;
  endtask

  // One WAIT=2 transaction with cycle-exact ack/busy checks; data via scoreboard.
  task automatic txn(input bit dm, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    exp_t e;
    @(negedge clk);
    if (dm) begin
      b2.dm_req = 1'b1; b2.dm_we = we; b2.dm_addr = a; b2.dm_wdata = wd;
    end else begin
      b2.if_req = 1'b1; b2.if_addr = a;
    end
    e.dm = dm; e.d = mdl[a];
    sb.push_back(e);
    if (dm && we) mdl[a] = wd;
    for (int k = 0; k <= W2 + 2; k++) begin
      @(negedge clk);
      chk("txn_busy", {31'd0, busy2}, {31'd0, (k <= W2 + 1)});
      chk("txn_own_ack", {31'd0, dm ? b2.dm_ack : b2.if_ack}, {31'd0, (k == W2 + 1)});
      chk("txn_other_ack", {31'd0, dm ? b2.if_ack : b2.dm_ack}, 32'd0);
      if (k == W2 + 1) begin
        b2.if_req = 1'b0; b2.dm_req = 1'b0;
      end
    end
  endtask

  initial begin
    logic [DW-1:0] exp_if;
    logic [DW-1:0] old20;
    int n, last, got;
    b2.if_req = 0; b2.if_addr = '0; b2.dm_req = 0; b2.dm_we = 0; b2.dm_addr = '0; b2.dm_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.dm_req = 0; b3.dm_we = 0; b3.dm_addr = '0; b3.dm_wdata = '0;
    b0.if_req = 0; b0.if_addr = '0; b0.dm_req = 0; b0.dm_we = 0; b0.dm_addr = '0; b0.dm_wdata = '0;

    preload2(5,  32'h2842_0005);
    preload2(10, 32'h0000_0000);
    for (int i = 0; i < 3; i++) u0.mem[i] = 32'h1000_0000 + 32'(i * 7 + 3);
    old20 = 32'hAAAA_0020;
    u3.mem[20] = old20;

    repeat (2) @(posedge clk);
    @(negedge clk);
    r2 = 1'b0; r3 = 1'b0; r0 = 1'b0;
    chk("rst_if_ack",   {31'd0, b2.if_ack}, 32'd0);
    chk("rst_dm_ack",   {31'd0, b2.dm_ack}, 32'd0);
    chk("rst_if_rdata", b2.if_rdata, 32'd0);
    chk("rst_dm_rdata", b2.dm_rdata, 32'd0);
    chk("rst_busy",     {31'd0, busy2}, 32'd0);

    // WAIT=2 fetch
    txn(1'b0, 1'b0, 10'd5, '0);
    exp_if = 32'h2842_0005;
    chk("fetch_if_rdata", b2.if_rdata, exp_if);

    // store then load, read-before-write
    txn(1'b1, 1'b1, 10'd10, 32'hDEAD_BEEF);
    chk("store_mem", u2.mem[10], 32'hDEAD_BEEF);
    txn(1'b1, 1'b0, 10'd10, '0);
    chk("load_dm_rdata", b2.dm_rdata, 32'hDEAD_BEEF);
    chk("if_untouched", b2.if_rdata, exp_if);

    // reset mid-stream: store aborted during WAIT, held for 2 cycles
    @(negedge clk);
    b2.dm_req = 1'b1; b2.dm_we = 1'b1; b2.dm_addr = 10'd10; b2.dm_wdata = 32'hBAD0_BAD0;
    @(negedge clk);
    r2 = 1'b1; b2.dm_req = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("midrst_if_ack",   {31'd0, b2.if_ack}, 32'd0);
      chk("midrst_dm_ack",   {31'd0, b2.dm_ack}, 32'd0);
      chk("midrst_if_rdata", b2.if_rdata, 32'd0);
      chk("midrst_dm_rdata", b2.dm_rdata, 32'd0);
      chk("midrst_busy",     {31'd0, busy2}, 32'd0);
    end
    r2 = 1'b0;
    chk("midrst_mem", u2.mem[10], mdl[10]);

    // contention after reset: DM, IF, DM, IF, WAIT+3 apart
    @(negedge clk);
    b2.if_req = 1'b1; b2.if_addr = 10'd5;
    b2.dm_req = 1'b1; b2.dm_we = 1'b0; b2.dm_addr = 10'd10;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.dm = (i % 2 == 0);
      e.d  = e.dm ? mdl[10] : mdl[5];
      sb.push_back(e);
    end
    n = 0; last = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(negedge clk);
      if (b2.if_ack || b2.dm_ack) begin
        if (n == 0) chk("cont_first", 32'(k), 32'(W2 + 1));
        else        chk("cont_gap", 32'(k - last), 32'(W2 + 3));
        last = k;
        n++;
        if (n == 4) begin b2.if_req = 1'b0; b2.dm_req = 1'b0; end
      end
    end
    chk("cont_count", 32'(n), 32'd4);
    @(negedge clk);
    chk("cont_ack_1cyc", {30'd0, b2.if_ack, b2.dm_ack}, 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // WAIT=3: reset at E2 aborts store; request held and re-sampled
    b3.dm_req = 1'b1; b3.dm_we = 1'b1; b3.dm_addr = 10'd20; b3.dm_wdata = 32'h1234_5678;
    @(posedge clk);            // E0
    @(posedge clk);            // E1
    @(negedge clk); r3 = 1'b1;
    @(posedge clk);            // E2
    @(negedge clk); r3 = 1'b0;
    chk("w3_busy_after_rst", {31'd0, busy3}, 32'd0);
    chk("w3_no_ack", {31'd0, b3.dm_ack}, 32'd0);
    chk("w3_mem_kept", u3.mem[20], old20);
    got = 0;
    for (int k = 0; k < 15 && got == 0; k++) begin
      @(negedge clk);
      if (b3.dm_ack) begin
        got = 1;
        chk("w3_reissue_rdata", b3.dm_rdata, old20);
        b3.dm_req = 1'b0;
      end
    end
    chk("w3_reissue_acked", 32'(got), 32'd1);
    chk("w3_mem_written", u3.mem[20], 32'h1234_5678);

    // WAIT=3: reset exactly on the access edge suppresses the write
    @(negedge clk);
    b3.dm_req = 1'b1; b3.dm_we = 1'b1; b3.dm_addr = 10'd20; b3.dm_wdata = 32'h5555_AAAA;
    repeat (W3 + 1) @(posedge clk);   // E0..E(W)
    @(negedge clk); r3 = 1'b1; b3.dm_req = 1'b0;
    @(posedge clk);                   // E(W+1), access edge
    @(negedge clk); r3 = 1'b0;
    chk("w3_access_rst_mem", u3.mem[20], 32'h1234_5678);
    chk("w3_access_rst_ack", {31'd0, b3.dm_ack}, 32'd0);

    // WAIT=0: back-to-back fetches of 0,1,2
    @(negedge clk);
    b0.if_req = 1'b1; b0.if_addr = 10'd0;
    n = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      chk("w0_busy", {31'd0, busy0}, {31'd0, (k % 3 != 2)});
      chk("w0_ack",  {31'd0, b0.if_ack}, {31'd0, (k % 3 == 1)});
      if (b0.if_ack) begin
        chk("w0_rdata", b0.if_rdata, 32'h1000_0000 + 32'(n * 7 + 3));
        n++;
        if (n == 3) b0.if_req = 1'b0;
        else        b0.if_addr = 10'(n);
      end
    end
    chk("w0_count", 32'(n), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Single-clock memory responder for the MIPS32 pipeline: the slave end of the instruction-fetch and data-memory accesses that the pipeline's IF and MEM stages issue. It holds a 2^ADDR_W × 32-bit word-addressed memory and serves two requester channels (IF read-only, DM read/write) through a req/ack handshake with a parameterised number of wait states. DM is arbitrated fairly against IF. The block sits between the pipeline core and its program/data store. Its purpose is to let the core be exercised against a memory with realistic, non-zero latency.

## Interface
Parameters:
- ADDR_W, 10, word-address width; memory depth is 2^ADDR_W words.
- DATA_W, 32, word width.
- WAIT, 1, wait states per access; legal range 0..7.

Ports:
- clk1  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- if_req  in  1  instruction-fetch request; held high until if_ack is seen.
- if_addr  in  ADDR_W  fetch word address.
- if_ack  out  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  out  DATA_W  fetched word, registered; holds its value between acks.
- dm_req  in  1  data request; held high until dm_ack is seen.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data word address.
- dm_wdata  in  DATA_W  store data.
- dm_ack  out  1  one-cycle pulse.
- dm_rdata  out  DATA_W  load data, registered. On a store it returns the pre-write contents.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If a request is pending: latch the grant (channel, addr, we, wdata), load cnt = WAIT, and go to WAIT.
- Arbitration in IDLE:
  - Only one channel requesting: grant that channel.
  - Both requesting: grant DM, unless last_grant == DM, in which case grant IF.
  - last_grant updates on every grant. Its reset value is IF, so DM wins the first contention.
- WAIT:
  - If cnt != 0: cnt decrements; stay in WAIT.
  - If cnt == 0: perform the access on this edge and go to RESP.
    - Read-before-write: the selected rdata register takes mem[addr], then mem[addr] takes wdata if this is a DM store.
    - The unselected channel's rdata is unchanged.
- RESP:
  - The granted channel's ack is high for exactly this cycle.
  - The next edge always returns to IDLE.
- Requester rule:
  - The requester deasserts req, or presents a new request, on the edge that ends its ack cycle.
  - req, addr and wdata must stay stable from assertion until ack.
  - Requests seen while the state is not IDLE are not sampled.
- Address width equals the memory index width, so there is no out-of-range case. Addresses wrap naturally.
- Memory contents are not cleared by reset; the bench preloads them hierarchically.
- Reset, at any edge where rst = 1:
  - State goes to IDLE; cnt = 0; last_grant = IF.
  - if_ack = dm_ack = 0; if_rdata = dm_rdata = 0; busy = 0.
  - An in-flight transaction is aborted. No ack is issued for it.
  - If rst coincides with the WAIT→RESP access edge, the write is suppressed and mem is unchanged.
  - The requester must re-issue the aborted request.

## Timing
- Edge E0 is the IDLE edge at which the request is sampled.
- The access happens at edge E(WAIT+1).
- ack is high from E(WAIT+1) to E(WAIT+2).
- The FSM is back in IDLE after E(WAIT+2). The earliest next sample edge is E(WAIT+3).
- Throughput: one transaction per WAIT+3 cycles.
- busy is high from E0 to E(WAIT+2), i.e. for WAIT+2 cycles.
- With WAIT=0: ack is seen after E1 and busy lasts 2 cycles.
- Read-after-write: a read issued after a store's ack returns the new data. No forwarding is needed.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset: rst high for 2 cycles mid-stream → if_ack = dm_ack = 0, if_rdata = dm_rdata = 0, busy = 0, state IDLE; mem contents unchanged.
- WAIT=2 fetch: mem[5]=32'h2842_0005; if_req with if_addr=5 sampled at E0 → if_ack high only between E3 and E4, if_rdata=32'h2842_0005; busy high E0..E4; dm_ack stays 0.
- Store then load: mem[10]=0. dm store 32'hDEADBEEF to address 10 → on its ack, dm_rdata=0. A following dm load of address 10 → dm_rdata=32'hDEADBEEF. if_rdata is untouched throughout.
- Contention: if_req and dm_req both held, each re-requesting immediately after its ack, for 4 transactions → ack order DM, IF, DM, IF. Each ack is exactly one cycle, with acks WAIT+3 cycles apart.
- Reset during WAIT: WAIT=3, dm store 32'h1234_5678 to address 20, rst pulsed at E2 → no dm_ack, busy=0 after E2, mem[20] keeps its old value. The re-issued store completes normally.
- WAIT=0 build: back-to-back IF reads of addresses 0, 1, 2 → acks after E1, E4, E7 with the correct words; busy is low for exactly one cycle between transactions.
